// File: rtl/matriz_scan_driver.sv
// matriz_scan_driver: time-multiplexed scan driver for a 5x7 dot-matrix sign.
// Takes whole 35-dot frames over a valid/ready handshake into a shadow buffer.
// The shadow moves to the display buffer only at the boundary before line 1,
// so a frame is never torn. The board is driven one line at a time: each line
// is lit for DWELL cycles, and an optional BLANK-cycle dark gap follows it.
module matriz_scan_driver #(
  parameter int DWELL          = 1000,
  parameter int BLANK          = 16,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        frame_start,
  output logic [4:0]  lin,
  output logic [6:0]  col
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [6:0]    COL_OFF    = COL_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    line_reg, line_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [34:0]   display_reg, display_next;
  logic [34:0]   shadow_reg, shadow_next;
  logic          shadow_full_reg, shadow_full_next;
  logic          swap_point;
  logic          swap_do;
  logic          accept;

  logic [6:0]    rows_next [5];
  logic [4:0]    lin_next;
  logic [6:0]    row_sel;
  logic [6:0]    col_next;
  logic          frame_start_next;

  // Scan sequencing: IDLE -> (BLANK) -> DRIVE per line; swap point flagged at the entry to line 1
  always_comb begin
    state_next = state_reg;
    line_next  = line_reg;
    cnt_next   = cnt_reg;
    swap_point = 1'b0;
    if (!enable) begin
      state_next = S_IDLE;
      line_next  = 3'd0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          line_next = 3'd0;
          cnt_next  = '0;
          if (BLANK > 0) begin
            state_next = S_BLANK;
          end else begin
            state_next = S_DRIVE;
            swap_point = 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = S_DRIVE;
            cnt_next   = '0;
            swap_point = (line_reg == 3'd0);
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_reg == DWELL_LAST) begin
            cnt_next  = '0;
            line_next = (line_reg == 3'd4) ? 3'd0 : line_reg + 3'd1;
            if (BLANK > 0) begin
              state_next = S_BLANK;
            end else begin
              state_next = S_DRIVE;
              swap_point = (line_reg == 3'd4);
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          line_next  = 3'd0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Buffer handoff: accept needs an empty shadow and swap needs a full one, so they never collide
  always_comb begin
    accept           = frame_valid && !shadow_full_reg;
    swap_do          = swap_point && shadow_full_reg;
    display_next     = swap_do ? shadow_reg : display_reg;
    shadow_next      = accept ? frame_in : shadow_reg;
    shadow_full_next = shadow_full_reg;
    if (accept) begin
      shadow_full_next = 1'b1;
    end else if (swap_do) begin
      shadow_full_next = 1'b0;
    end
  end

  // Slice the upcoming display buffer into rows and decode the one-hot line select
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_line
      assign rows_next[gi] = display_next[gi*7 +: 7];
      assign lin_next[gi]  = (state_next == S_DRIVE) && (line_next == 3'(gi));
    end
  endgenerate

  // Output values for the next cycle, taken from the next state so outputs stay aligned with the FSM
  always_comb begin
    row_sel          = rows_next[line_next];
    col_next         = COL_OFF;
    frame_start_next = 1'b0;
    if (state_next == S_DRIVE) begin
      col_next         = COL_ACTIVE_LOW ? ~row_sel : row_sel;
      frame_start_next = (line_next == 3'd0) && (cnt_next == '0);
    end
  end

  // State, buffers and registered outputs; reset drops any pending shadow frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      line_reg        <= 3'd0;
      cnt_reg         <= '0;
      display_reg     <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      lin             <= 5'd0;
      col             <= COL_OFF;
      frame_start     <= 1'b0;
      frame_ready     <= 1'b1;
    end else begin
      state_reg       <= state_next;
      line_reg        <= line_next;
      cnt_reg         <= cnt_next;
      display_reg     <= display_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      lin             <= lin_next;
      col             <= col_next;
      frame_start     <= frame_start_next;
      frame_ready     <= !shadow_full_next;
    end
  end

endmodule
